axi_rd_traffic_gen: RTL and testbench

AXI4 read-initiator traffic generator. It drives the AR channel and consumes the R channel of a memory-model slave, such as the delayed-AR DRAM model. It takes one command describing a strided sequence of INCR bursts, keeps up to MAX_OUTSTANDING bursts in flight, and checks R-channel ordering, burst framing and response codes. It also accumulates a data checksum and a total-latency count for performance benches.

---
 rtl/axi_rd_traffic_gen.sv | 181 ++++++++++++++++++
 tb/tb_axi_rd_traffic_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_traffic_gen.sv
// AXI4 read-initiator traffic generator: issues a strided run of INCR bursts,
// consumes the R channel in order, and reports beat count, data XOR, latency and protocol errors.
module axi_rd_traffic_gen #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [CNT_WIDTH-1:0]  cmd_num,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [DATA_WIDTH-1:0] data_sum,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]        OUT_ONE = OW'(1);
  localparam logic [OW-1:0]        OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]  ID_ONE  = ID_WIDTH'(1);
  localparam logic [2:0]           ARSIZE  = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [7:0]            len_q, beat_q;
  logic [CNT_WIDTH-1:0]  num_q, issued_q, issued_d, recv_q;
  logic [OW-1:0]         outst_q, outst_d;
  logic [ID_WIDTH-1:0]   arid_q, exp_rid_q;
  logic                  arvalid_q, arvalid_d;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  beat_count_q, cycle_count_q;
  logic [DATA_WIDTH-1:0] data_sum_q;

  logic cmd_accept, ar_hs, r_hs, burst_close, final_close, outst_dec;

  assign cmd_ready     = (state_q == IDLE);
  assign m_axi_rready  = (state_q == RUN);
  assign done          = (state_q == FIN);
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = arid_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = ARSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign err           = err_q;
  assign beat_count    = beat_count_q;
  assign data_sum      = data_sum_q;
  assign cycle_count   = cycle_count_q;

  assign cmd_accept  = cmd_valid & cmd_ready;
  assign ar_hs       = arvalid_q & m_axi_arready;
  assign r_hs        = m_axi_rvalid & m_axi_rready;
  // A burst closes when the beat counter reaches arlen, whatever rlast says.
  assign burst_close = r_hs & (beat_q == len_q);
  assign final_close = burst_close & ((recv_q + CNT_ONE) == num_q);
  assign outst_dec   = burst_close & (outst_q != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    outst_d   = outst_q;
    arvalid_d = 1'b0;

    if (ar_hs) issued_d = issued_q + CNT_ONE;
    case ({ar_hs, outst_dec})
      2'b10:   outst_d = outst_q + OUT_ONE;
      2'b01:   outst_d = outst_q - OUT_ONE;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: if (cmd_accept) state_d = (cmd_num == '0) ? FIN : RUN;
      RUN:  if (final_close) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // arvalid only falls after a handshake: while it waits, issued is frozen
    // and outstanding can only shrink, so the issue condition stays true.
    if (cmd_accept)
      arvalid_d = (cmd_num != '0);
    else if (state_d == RUN)
      arvalid_d = (issued_d < num_q) && (outst_d < OUT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      recv_q        <= '0;
      outst_q       <= '0;
      beat_q        <= '0;
      arid_q        <= '0;
      exp_rid_q     <= '0;
      arvalid_q     <= 1'b0;
      err_q         <= 1'b0;
      beat_count_q  <= '0;
      data_sum_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      if (cmd_accept) begin
        addr_q        <= cmd_addr;
        stride_q      <= cmd_stride;
        len_q         <= cmd_len;
        num_q         <= cmd_num;
        issued_q      <= '0;
        recv_q        <= '0;
        outst_q       <= '0;
        beat_q        <= '0;
        arid_q        <= '0;
        exp_rid_q     <= '0;
        err_q         <= 1'b0;
        beat_count_q  <= '0;
        data_sum_q    <= '0;
        cycle_count_q <= '0;
      end else begin
        issued_q <= issued_d;
        outst_q  <= outst_d;
        if (ar_hs) begin
          addr_q <= addr_q + stride_q;
          arid_q <= arid_q + ID_ONE;
        end
        if (r_hs) begin
          beat_count_q <= beat_count_q + CNT_ONE;
          data_sum_q   <= data_sum_q ^ m_axi_rdata;
          if ((m_axi_rresp != 2'b00) || (m_axi_rid != exp_rid_q) ||
              (m_axi_rlast != (beat_q == len_q)) || (outst_q == '0))
            err_q <= 1'b1;
          if (burst_close) begin
            beat_q    <= '0;
            recv_q    <= recv_q + CNT_ONE;
            exp_rid_q <= exp_rid_q + ID_ONE;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        if ((state_q == RUN) && (cycle_count_q != '1))
          cycle_count_q <= cycle_count_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_traffic_gen.sv
// Bench for axi_rd_traffic_gen: a scripted/random AXI read slave plus a
// transaction-level model of the expected addresses, ids, beat totals and XOR sum.
module tb_axi_rd_traffic_gen;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MO = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr, cmd_stride;
  logic [7:0]    cmd_len;
  logic [CW-1:0] cmd_num;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid, m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic          done, err;
  logic [CW-1:0] beat_count, cycle_count;
  logic [DW-1:0] data_sum;

  axi_rd_traffic_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_num(cmd_num), .cmd_stride(cmd_stride),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .done(done), .err(err), .beat_count(beat_count), .data_sum(data_sum),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // ar_mode: 0 always ready, 1 stall the first 12 cycles, 2 random.
  // fault:   0 none, 1 bad rresp, 2 early rlast at beat 1, 3 wrong rid (all on burst 0).
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [CW-1:0] num;
    logic [AW-1:0] stride;
    int            ar_mode;
    int            rnd_data;
    int            fault;
    bit            exp_err;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [AW-1:0] exp_addr, prev_addr;
    logic [IW-1:0] prev_id;
    logic [DW-1:0] exp_sum;
    int bq[$];
    int bi, ar_cnt, beats, outst, done_cyc, k, tmp;
    bit r_taken, prev_stall, stable_ok, outst_ok, seen_done, ar_hs, r_hs;
    exp_addr = v.addr; exp_sum = '0;
    bi = 0; ar_cnt = 0; beats = 0; outst = 0; done_cyc = 0;
    r_taken = 0; prev_stall = 0; stable_ok = 1; outst_ok = 1; seen_done = 0;
    prev_addr = '0; prev_id = '0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len;
    cmd_num = v.num; cmd_stride = v.stride;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    #1 check("cmd_ready_idle", cmd_ready, 1);

    for (int cyc = 1; cyc <= 4000 && !seen_done; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (v.ar_mode)
        0: m_axi_arready = 1'b1;
        1: m_axi_arready = (cyc > 12);
        default: m_axi_arready = ($urandom_range(0, 1) == 1);
      endcase
      if (r_taken) begin
        r_taken = 0;
        m_axi_rvalid = 1'b0;
        bi++;
        if (bi > int'(v.len)) begin
          tmp = bq.pop_front();
          bi = 0;
        end
      end
      if (!m_axi_rvalid && bq.size() > 0 && (v.ar_mode != 2 || $urandom_range(0, 2) != 0)) begin
        k = bq[0];
        m_axi_rvalid = 1'b1;
        m_axi_rid    = IW'(k);
        m_axi_rdata  = v.rnd_data != 0 ? DW'($urandom) : DW'(bi);
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = (bi == int'(v.len));
        if (k == 0) begin
          if (v.fault == 1 && bi == (v.len >= 1 ? 1 : 0)) m_axi_rresp = 2'b10;
          if (v.fault == 2 && bi == 1) m_axi_rlast = 1'b1;
          if (v.fault == 3 && bi == 0) m_axi_rid = IW'(1);
        end
      end

      #1;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (prev_stall && (!m_axi_arvalid || m_axi_araddr != prev_addr || m_axi_arid != prev_id))
        stable_ok = 0;
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev_addr  = m_axi_araddr;
      prev_id    = m_axi_arid;
      if (ar_hs) begin
        check("araddr", m_axi_araddr, exp_addr);
        check("arid", m_axi_arid, IW'(ar_cnt));
        check("arlen", m_axi_arlen, v.len);
        bq.push_back(ar_cnt);
        ar_cnt++;
        exp_addr = exp_addr + v.stride;
        outst++;
        if (outst > MO) outst_ok = 0;
      end
      if (r_hs) begin
        exp_sum ^= m_axi_rdata;
        beats++;
        r_taken = 1;
        if (bi == int'(v.len)) outst--;
      end
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
    end

    check("done_seen", seen_done, 1);
    check("ar_count", ar_cnt, v.num);
    check("ar_stable", stable_ok, 1);
    check("max_outstanding", outst_ok, 1);
    check("err", err, v.exp_err);
    check("beat_count", beat_count, CW'(int'(v.num) * (int'(v.len) + 1)));
    check("beats_accepted", beat_count, CW'(beats));
    check("data_sum", data_sum, exp_sum);
    check("cycle_count", cycle_count, CW'(done_cyc - 1));

    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
    #1;
    check("done_pulse_one_cycle", done, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("rready_idle", m_axi_rready, 0);
    check("beat_count_hold", beat_count, CW'(int'(v.num) * (int'(v.len) + 1)));
  endtask

  task automatic reset_mid_run();
    int ar_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 16'h0040; cmd_len = 8'd3;
    cmd_num = 16'd8; cmd_stride = 16'h0020;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0;
    ar_cnt = 0;
    for (int cyc = 0; cyc < 50 && ar_cnt < 2; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 if (m_axi_arvalid && m_axi_arready) ar_cnt++;
    end
    check("rst_two_ars", ar_cnt, 2);
    check("rst_arvalid_before", m_axi_arvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_arvalid_drop", m_axi_arvalid, 0);
    check("rst_rready_drop", m_axi_rready, 0);
    check("rst_done", done, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    m_axi_arready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_num = '0; cmd_stride = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 1'b0;

    tbl[0] = '{16'h0100, 8'd3, 16'd4,  16'h0010, 0, 0, 0, 1'b0};
    tbl[1] = '{16'h0200, 8'd1, 16'd4,  16'h0040, 1, 1, 0, 1'b0};
    tbl[2] = '{16'hFFF0, 8'd0, 16'd3,  16'h0010, 0, 1, 0, 1'b0};
    tbl[3] = '{16'h1000, 8'd3, 16'd2,  16'h0010, 2, 1, 1, 1'b1};
    tbl[4] = '{16'h2000, 8'd3, 16'd1,  16'h0010, 0, 1, 2, 1'b1};
    tbl[5] = '{16'h3000, 8'd2, 16'd3,  16'h0100, 2, 1, 3, 1'b1};
    tbl[6] = '{16'h4000, 8'd3, 16'd0,  16'h0010, 0, 1, 0, 1'b0};
    tbl[7] = '{16'h0500, 8'd7, 16'd10, 16'h0080, 2, 1, 0, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("reset_arvalid", m_axi_arvalid, 0);
    check("reset_rready", m_axi_rready, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_beat_count", beat_count, 0);
    check("reset_data_sum", data_sum, 0);
    check("reset_cycle_count", cycle_count, 0);
    check("arsize", m_axi_arsize, 3'd2);
    check("arburst", m_axi_arburst, 2'b01);
    check("arcache", m_axi_arcache, 4'b0011);
    check("arlock_arprot", {m_axi_arlock, m_axi_arprot}, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

    reset_mid_run();
    run_cmd(tbl[0]);

    for (int i = 0; i < 6; i++) begin
      v.addr     = AW'($urandom);
      v.stride   = AW'($urandom);
      v.len      = 8'($urandom_range(0, 7));
      v.num      = CW'($urandom_range(0, 9));
      v.ar_mode  = $urandom_range(0, 2);
      v.rnd_data = 1;
      v.fault    = $urandom_range(0, 3);
      if (v.fault == 2 && v.len < 2) v.fault = 0;
      v.exp_err  = (v.fault != 0) && (v.num != 0);
      run_cmd(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
